// File: rtl/robot_clock_ctrl.sv
// robot_clock_ctrl: conditions the mode and clock push-buttons, keeps the
// automatic/manual mode flag and produces the robot step clock plus a
// one-cycle strobe on the first cycle of every step pulse.
module robot_clock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_DIV        = 25000000,
    parameter int HIGH_CYCLES     = 2
) (
    input  logic clock_50,
    input  logic reset,
    input  logic mode_toggle,
    input  logic clock_toggle,
    output logic mode,
    output logic robot_clock,
    output logic robot_tick
);

    localparam int DBC_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ACNT_W = $clog2(AUTO_DIV);
    localparam int HCNT_W = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;

    localparam logic [DBC_W-1:0]  DBC_MAX  = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ACNT_W-1:0] ACNT_MAX = ACNT_W'(AUTO_DIV - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HIGH_CYCLES - 1);

    // Bit 0 is the mode key, bit 1 is the clock key; both active-low.
    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {clock_toggle, mode_toggle};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             clean_reg;
            logic             clean_d_reg;
            logic [DBC_W-1:0] dbc_reg;

            // Two-flop synchroniser, then a level debouncer that accepts a new
            // level only after it has been stable for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge clock_50 or posedge reset) begin
                if (reset) begin
                    sync1_reg   <= 1'b1;
                    sync2_reg   <= 1'b1;
                    clean_reg   <= 1'b1;
                    clean_d_reg <= 1'b1;
                    dbc_reg     <= '0;
                end else begin
                    sync1_reg   <= key_raw[gi];
                    sync2_reg   <= sync1_reg;
                    clean_d_reg <= clean_reg;
                    if (sync2_reg == clean_reg) begin
                        dbc_reg <= '0;
                    end else if (dbc_reg == DBC_MAX) begin
                        clean_reg <= sync2_reg;
                        dbc_reg   <= '0;
                    end else begin
                        dbc_reg <= dbc_reg + DBC_W'(1);
                    end
                end
            end

            // A press is the falling edge of the clean level; release is ignored.
            assign press[gi] = ~clean_reg & clean_d_reg;
        end
    endgenerate

    logic              mode_reg;
    logic [ACNT_W-1:0] acnt_reg;
    logic              auto_wrap;
    logic              trigger;

    assign auto_wrap = ~mode_reg && (acnt_reg == ACNT_MAX);
    // Trigger source follows the registered mode, so a clock press coinciding
    // with a mode press is judged against the mode before the flip.
    assign trigger   = mode_reg ? press[1] : auto_wrap;

    // Mode flag and automatic-rate counter; every flip restarts the period.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            mode_reg <= 1'b0;
            acnt_reg <= '0;
        end else if (press[0]) begin
            mode_reg <= ~mode_reg;
            acnt_reg <= '0;
        end else if (mode_reg) begin
            acnt_reg <= '0;
        end else if (acnt_reg == ACNT_MAX) begin
            acnt_reg <= '0;
        end else begin
            acnt_reg <= acnt_reg + ACNT_W'(1);
        end
    end

    typedef enum logic {
        IDLE,
        HIGH
    } pulse_state_t;

    pulse_state_t      state_reg,       state_next;
    logic [HCNT_W-1:0] hcnt_reg,        hcnt_next;
    logic              robot_clock_reg, robot_clock_next;
    logic              robot_tick_reg,  robot_tick_next;

    // Pulse engine state and output registers.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            hcnt_reg        <= '0;
            robot_clock_reg <= 1'b0;
            robot_tick_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hcnt_reg        <= hcnt_next;
            robot_clock_reg <= robot_clock_next;
            robot_tick_reg  <= robot_tick_next;
        end
    end

    // Next-state logic: triggers seen while HIGH are dropped, and the pulse
    // always runs its full length regardless of mode changes.
    always_comb begin
        state_next       = state_reg;
        hcnt_next        = hcnt_reg;
        robot_clock_next = robot_clock_reg;
        robot_tick_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    state_next       = HIGH;
                    hcnt_next        = '0;
                    robot_clock_next = 1'b1;
                    robot_tick_next  = 1'b1;
                end
            end
            HIGH: begin
                if (hcnt_reg == HCNT_MAX) begin
                    state_next       = IDLE;
                    robot_clock_next = 1'b0;
                end else begin
                    hcnt_next = hcnt_reg + HCNT_W'(1);
                end
            end
            default: begin
                state_next       = IDLE;
                robot_clock_next = 1'b0;
            end
        endcase
    end

    assign mode        = mode_reg;
    assign robot_clock = robot_clock_reg;
    assign robot_tick  = robot_tick_reg;

endmodule
